aes256_key_expand: RTL and testbench

AES256_KEY_EXPAND -- requirements
Module: aes256_key_expand

---
 rtl/aes256_key_expand.sv | 190 +++++++++++++++++++
 tb/tb_aes256_key_expand.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_key_expand.sv
// AES-256 key expansion: streams round keys 0..14 from a 256-bit sliding window, one per accepted handshake.
// Latency: start sampled at edge N gives round key 0 valid from edge N+1; each handshake presents the next key the following cycle.
// Backpressure: rk_ready low freezes round_key, rk_idx and the window; optional round-key store under KEYEXP_STORE_EN.

// AES forward S-box, purely combinational table lookup.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte 0 sits in the top eight bits, so the bit offset is (255 - in_byte) * 8.
    assign out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];
endmodule

module aes256_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    input  logic         rk_ready,
`ifdef KEYEXP_STORE_EN
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         store_valid,
`endif
    output logic         rk_valid,
    output logic [127:0] round_key,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [3:0] LAST_IDX = 4'd14;

    logic [0:0]   state_q, state_d;
    logic [255:0] w_q, w_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic         rk_valid_q, rk_valid_d;
    logic         done_q, done_d;

    logic         hs;
    logic [31:0]  w7, sub_in, sub_out, t_word;
    logic [31:0]  n0, n1, n2, n3;

    assign hs = rk_valid_q & rk_ready;

    // The window holds w[4r..4r+7]; the words appended on a handshake are
    // w[4r+8..4r+11]. They open a new 8-word group (rotate + rcon) when r is
    // even, and are the mid-group SubWord-only step when r is odd.
    assign w7     = w_q[31:0];
    assign sub_in = rk_idx_q[0] ? w7 : {w7[23:0], w7[31:24]};

    aes_sbox u_sbox3 (.in_byte(sub_in[31:24]), .out_byte(sub_out[31:24]));
    aes_sbox u_sbox2 (.in_byte(sub_in[23:16]), .out_byte(sub_out[23:16]));
    aes_sbox u_sbox1 (.in_byte(sub_in[15:8]),  .out_byte(sub_out[15:8]));
    aes_sbox u_sbox0 (.in_byte(sub_in[7:0]),   .out_byte(sub_out[7:0]));

    assign t_word = rk_idx_q[0] ? sub_out : (sub_out ^ {rcon_q, 24'h000000});
    assign n0     = w_q[255:224] ^ t_word;
    assign n1     = w_q[223:192] ^ n0;
    assign n2     = w_q[191:160] ^ n1;
    assign n3     = w_q[159:128] ^ n2;

    // Next-state: accept start in IDLE, advance the window on each handshake in RUN.
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        rcon_d     = rcon_q;
        rk_idx_d   = rk_idx_q;
        rk_valid_d = rk_valid_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    w_d        = key;
                    rcon_d     = 8'h01;
                    rk_idx_d   = 4'd0;
                    rk_valid_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (hs) begin
                    if (rk_idx_q == LAST_IDX) begin
                        state_d    = ST_IDLE;
                        rk_valid_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        w_d      = {w_q[127:0], n0, n1, n2, n3};
                        rk_idx_d = rk_idx_q + 4'd1;
                        // 8'h40 is the last rcon AES-256 consumes; hold it there.
                        if (!rk_idx_q[0] && (rcon_q != 8'h40)) begin
                            rcon_d = {rcon_q[6:0], 1'b0};
                        end
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                rk_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; synchronous reset overrides start and handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            w_q        <= '0;
            rcon_q     <= 8'h01;
            rk_idx_q   <= 4'd0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            rcon_q     <= rcon_d;
            rk_idx_q   <= rk_idx_d;
            rk_valid_q <= rk_valid_d;
            done_q     <= done_d;
        end
    end

    assign rk_valid  = rk_valid_q;
    assign round_key = w_q[255:128];
    assign rk_idx    = rk_idx_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;

`ifdef KEYEXP_STORE_EN
    logic [127:0] rf_q [15];
    logic [127:0] rf_d [15];
    logic [127:0] rd_key_q, rd_key_d;
    logic         store_valid_q, store_valid_d;

    // Capture each accepted key by index; registered read port, out-of-range reads as zero.
    always_comb begin
        rf_d          = rf_q;
        store_valid_d = store_valid_q;
        rd_key_d      = '0;
        if (hs) begin
            rf_d[rk_idx_q] = w_q[255:128];
        end
        if ((state_q == ST_IDLE) && start) begin
            store_valid_d = 1'b0;
        end else if (hs && (rk_idx_q == LAST_IDX)) begin
            store_valid_d = 1'b1;
        end
        if (rd_idx <= LAST_IDX) begin
            rd_key_d = rf_q[rd_idx];
        end
    end

    // Store registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q          <= '{default: '0};
            rd_key_q      <= '0;
            store_valid_q <= 1'b0;
        end else begin
            rf_q          <= rf_d;
            rd_key_q      <= rd_key_d;
            store_valid_q <= store_valid_d;
        end
    end

    assign rd_key      = rd_key_q;
    assign store_valid = store_valid_q;
`endif
endmodule

// File: tb/tb_aes256_key_expand.sv
// Bench for aes256_key_expand: FIPS-197 key schedule model built from GF(2^8) arithmetic.
module tb_aes256_key_expand;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] key;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] round_key;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;
`ifdef KEYEXP_STORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         store_valid;
`endif

    localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] sb [256];

    always #5 clk = ~clk;

    aes256_key_expand dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .rk_ready(rk_ready),
`ifdef KEYEXP_STORE_EN
        .rd_idx(rd_idx), .rd_key(rd_key), .store_valid(store_valid),
`endif
        .rk_valid(rk_valid), .round_key(round_key), .rk_idx(rk_idx),
        .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from first principles: multiplicative inverse then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] xb;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(xb, y[7:0]) == 8'h01) inv = y[7:0];
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    // Textbook AES-256 key schedule; round key r lives at bits [r*128 +: 128].
    function automatic logic [1919:0] expand(input logic [255:0] k);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1919:0] out = '0;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) out[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return out;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(input bit rnd, input int max_cyc, input string name);
        bit found = 1'b0;
        for (int c = 0; c < max_cyc && !found; c++) begin
            step();
            if (rnd) rk_ready = 1'($urandom_range(0, 1));
            if (done === 1'b1) found = 1'b1;
        end
        chk(name, {127'd0, found}, 128'd1);
    endtask

    // Compare process: tracks the expected handshake sequence and checks every cycle.
    initial begin
        bit            armed     = 1'b0;
        bit            exp_valid = 1'b0;
        bit            pend_done = 1'b0;
        bit            exp_zero  = 1'b0;
        int            exp_idx   = 0;
        logic [1919:0] model     = '0;
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("rk_valid", {127'd0, rk_valid}, {127'd0, exp_valid});
                chk("busy", {127'd0, busy}, {127'd0, exp_valid});
                chk("done", {127'd0, done}, {127'd0, pend_done});
                if (exp_valid) begin
                    chk("rk_idx", {124'd0, rk_idx}, 128'(exp_idx));
                    chk("round_key", round_key, model[exp_idx*128 +: 128]);
                end
                if (exp_zero) begin
                    chk("reset_round_key", round_key, 128'd0);
                    chk("reset_rk_idx", {124'd0, rk_idx}, 128'd0);
                end
            end
            if (rst) begin
                armed     = 1'b1;
                exp_valid = 1'b0;
                exp_idx   = 0;
                pend_done = 1'b0;
                exp_zero  = 1'b1;
            end else begin
                pend_done = 1'b0;
                if (exp_valid) begin
                    if (rk_ready) begin
                        if (exp_idx == 14) begin
                            exp_valid = 1'b0;
                            pend_done = 1'b1;
                        end else begin
                            exp_idx++;
                        end
                    end
                end else if (start) begin
                    exp_valid = 1'b1;
                    exp_idx   = 0;
                    exp_zero  = 1'b0;
                    model     = expand(key);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [1919:0] m;
        bit            f;
        rst      = 1'b1;
        start    = 1'b0;
        key      = '0;
        rk_ready = 1'b0;
`ifdef KEYEXP_STORE_EN
        rd_idx   = 4'd0;
`endif
        build_sbox();

        // Pin the model against published FIPS-197 values.
        m = expand(K1);
        chk("model_rk0", m[0 +: 128], 128'h000102030405060708090a0b0c0d0e0f);
        chk("model_rk1", m[128 +: 128], 128'h101112131415161718191a1b1c1d1e1f);
        chk("model_rk2", m[256 +: 128], 128'ha573c29fa176c498a97fce93a572c09c);
        chk("model_rk14", m[1792 +: 128], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        m = expand(K2);
        chk("model_k2_rk2", m[256 +: 128], 128'h9ba354118e6925afa51a8b5f2067fcde);

        repeat (2) step();
        rst = 1'b0;
        step();

        // Full-throughput expansion; key changes after acceptance.
        key = K1; start = 1'b1; rk_ready = 1'b1;
        step();
        start = 1'b0; key = K2;
        run_until_done(1'b0, 100, "done_full_rate");

        // Random backpressure.
        step();
        key = K1; start = 1'b1;
        step();
        start = 1'b0;
        run_until_done(1'b1, 600, "done_random_ready");
        rk_ready = 1'b1;

        // Start re-pulsed with another key during RUN.
        step();
        key = K1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        key = K2; start = 1'b1;
        step();
        start = 1'b0;
        run_until_done(1'b0, 100, "done_ignored_start");

        // Reset at index 6, together with a start and a pending handshake.
        key = K2; start = 1'b1;
        step();
        start = 1'b0;
        f = 1'b0;
        for (int c = 0; c < 50 && !f; c++) begin
            if (rk_valid === 1'b1 && rk_idx == 4'd6) f = 1'b1;
            else step();
        end
        chk("reach_idx6", {127'd0, f}, 128'd1);
        rst = 1'b1; start = 1'b1; key = K1;
        step();
        rst = 1'b0; start = 1'b0;
        chk("abort_rk_valid", {127'd0, rk_valid}, 128'd0);
        chk("abort_busy", {127'd0, busy}, 128'd0);
        step();
        key = K2; start = 1'b1;
        step();
        start = 1'b0;
        run_until_done(1'b0, 100, "done_after_abort");

        // Start held high through done restarts in the done cycle.
        key = K1; start = 1'b1;
        run_until_done(1'b0, 100, "done_held_first");
        step();
        chk("held_restart_valid", {127'd0, rk_valid}, 128'd1);
        chk("held_restart_idx", {124'd0, rk_idx}, 128'd0);
        start = 1'b0;
        run_until_done(1'b0, 100, "done_held_second");

`ifdef KEYEXP_STORE_EN
        chk("store_valid_set", {127'd0, store_valid}, 128'd1);
        rd_idx = 4'd2;
        step();
        chk("rd_key_2", rd_key, 128'ha573c29fa176c498a97fce93a572c09c);
        rd_idx = 4'd14;
        step();
        chk("rd_key_14", rd_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        rd_idx = 4'd15;
        step();
        chk("rd_key_15", rd_key, 128'd0);
        key = K2; start = 1'b1;
        step();
        start = 1'b0;
        chk("store_valid_cleared", {127'd0, store_valid}, 128'd0);
        run_until_done(1'b0, 100, "done_store_k2");
`endif

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
